c_lkp_rob: RTL and testbench
============================

# c_lkp_rob

Parametrised lookup reorder buffer for the C module datapath. Accepts packets from B, issues a lookup to A for packets with lookup enabled, absorbs out-of-order A responses by request ID, and releases packets to D strictly in B arrival order with the lookup result attached. It generalises C's fixed single-configuration lookup path in depth, field widths and timeout handling.

## Interface
Parameters:
- REQ_ID_W, 4: request-ID width; ROB depth DEPTH = 2**REQ_ID_W
- LKP_INFO_W, 32: lookup key width
- LKP_RSLT_W, 16: lookup result width
- ODR_ID_W, 8: order-ID width, passed through unchanged
- PAYLOAD_W, 128: payload width
- LKP_TIMEOUT, 1024: head wait limit in cycles; used only with C_LKP_TMO_EN

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- b2c_pkt_vld  in  1  B packet valid
- b2c_pkt_lkp_en  in  1  packet needs a lookup
- b2c_pkt_lkp_info  in  LKP_INFO_W  lookup key
- b2c_pkt_odr_id  in  ODR_ID_W  order ID
- b2c_pkt_so  in  1  sideband bit, passed through
- b2c_pkt_payload  in  PAYLOAD_W  payload
- c2b_pkt_rdy  out  1  ready to B
- c2a_lkp_vld  out  1  lookup request valid
- c2a_lkp_info  out  LKP_INFO_W  lookup key
- c2a_lkp_req_id  out  REQ_ID_W  ROB slot index
- a2c_lkp_rdy  in  1  A accepts request
- a2c_lkp_rsp_vld  in  1  response valid; no backpressure
- a2c_lkp_rsp_id  in  REQ_ID_W  responding slot
- a2c_lkp_rslt  in  LKP_RSLT_W  result
- c2d_pkt_vld  out  1  output valid
- c2d_pkt_lkp_rslt  out  LKP_RSLT_W  result; 0 if no lookup
- c2d_pkt_odr_id  out  ODR_ID_W  order ID
- c2d_pkt_so  out  1  sideband
- c2d_pkt_payload  out  PAYLOAD_W  payload
- d2c_pkt_rdy  in  1  D ready
- c_rob_err  out  1  sticky protocol error
- c2d_pkt_tmo  out  1  released by timeout; present only with C_LKP_TMO_EN

## Operation
- ROB is circular: head and tail pointers are REQ_ID_W bits and wrap naturally. Occupancy count is REQ_ID_W+1 bits.
- Each slot holds one of three states: FREE, WAIT (lookup outstanding or not yet issued), READY.
- B accept: a transfer occurs on b2c_pkt_vld && c2b_pkt_rdy.
  - The packet is written at tail and tail increments.
  - If lkp_en=0, the slot becomes READY with rslt=0.
  - If lkp_en=1, the slot becomes WAIT. The issue register loads {info, req_id=tail} and sets c2a_lkp_vld.
- c2b_pkt_rdy = (count < DEPTH) && (!c2a_lkp_vld || a2c_lkp_rdy).
  - This is combinational on a2c_lkp_rdy.
  - Rdy deliberately ignores lkp_en and ignores a same-cycle D release.
- Issue register: c2a_lkp_vld holds with stable fields until a2c_lkp_rdy. It clears after the handshake unless it is reloaded in the same cycle.
- Response: a2c_lkp_rsp_vld writes the result into slot rsp_id and sets that slot READY, but only if the slot is in WAIT. A response to a FREE or READY slot is dropped and sets c_rob_err.
- Release: c2d_pkt_vld = (count > 0) && state[head]==READY. Output fields come from the head slot.
  - On d2c_pkt_rdy, the slot becomes FREE and head increments.
  - Outputs stay stable while vld && !rdy.
- Simultaneous accept, response and release in one cycle are independent. count updates by +accept −release.
- Contract on A: a response arrives at least one cycle after its request handshake.

## Timing
- Reset values:
  - c2b_pkt_rdy=0 while rst is asserted.
  - c2a_lkp_vld=0, c2d_pkt_vld=0, c_rob_err=0, c2d_pkt_tmo=0.
  - Data outputs are 0.
  - All slots FREE; head=tail=count=0.
- Accept in cycle N:
  - c2a_lkp_vld is asserted in N+1.
  - A non-lookup packet at head gives c2d_pkt_vld in N+1.
- Response in cycle M for the head slot gives c2d_pkt_vld in M+1.
- Throughput is one packet per cycle on every interface.
- Reset asserted mid-operation clears all state immediately. Outstanding A responses after reset deassertion are dropped and flagged.

## Configuration
- C_LKP_TMO_EN defined:
  - A TMO counter runs while the head slot is WAIT and resets on head change.
  - When the counter reaches LKP_TIMEOUT, the head becomes READY with rslt = all ones. c2d_pkt_tmo=1 accompanies that release.
  - A later response to that slot follows the normal drop-and-flag rule while the slot is not WAIT.
- Undefined: no counter and no c2d_pkt_tmo port. The head waits indefinitely.

## Structure
- c_module_pkg gains:
  - the slot state enum (FREE/WAIT/READY)
  - the constant C_RSLT_NONE=0
  - the timeout result fill rule (all ones)
- Sub-module c_lkp_issue_reg: a one-entry valid/ready holding register for the A request.

## Test plan
- Four non-lookup packets with no backpressure -> D receives them in order, each one cycle after accept, with rslt=0.
- Packets at slots 0,1,2 with lkp_en=1; responses arrive in order 2,0,1 with rslts 0x22,0x00,0x11 -> D order is 0,1,2 with rslts 0x00,0x11,0x22; nothing is released before the slot-0 response.
- Fill all DEPTH slots with d2c_pkt_rdy=0 -> c2b_pkt_rdy drops at count=16; one release restores rdy the next cycle; tail wraps to slot 0 correctly.
- a2c_lkp_rdy held low for 5 cycles -> c2a_lkp_vld and fields are stable throughout, and c2b_pkt_rdy=0 while the issue register is occupied.
- Response to a FREE slot (id 7) -> dropped and c_rob_err=1 until reset; a reset pulse mid-traffic clears all state, with c2d_pkt_vld=0 the same cycle.
- With C_LKP_TMO_EN and LKP_TIMEOUT=8, withhold the head response -> release on the 8th WAIT cycle with rslt=0xFFFF and c2d_pkt_tmo=1; a late response sets c_rob_err.

Source files
------------

// File: rtl/c_module_pkg.sv
// Shared types and constants for the C module datapath: ROB slot states and
// the fixed lookup-result fills used when no real result is available.
package c_module_pkg;

  typedef enum logic [1:0] {
    SLOT_FREE  = 2'd0,
    SLOT_WAIT  = 2'd1,
    SLOT_READY = 2'd2
  } slot_state_e;

  // Result carried by packets that never requested a lookup.
  localparam int C_RSLT_NONE = 0;

  // A timed-out lookup reports a result with every bit set to this value.
  localparam bit C_RSLT_TMO_FILL = 1'b1;

endpackage

// File: rtl/c_lkp_issue_reg.sv
// One-entry valid/ready holding register for the lookup request to A.
// Fields stay stable while vld is high and rdy is low.
module c_lkp_issue_reg #(
  parameter int INFO_W = 32,
  parameter int ID_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [INFO_W-1:0] load_info,
  input  logic [ID_W-1:0]   load_id,
  output logic              free,
  output logic              vld,
  output logic [INFO_W-1:0] info,
  output logic [ID_W-1:0]   id,
  input  logic              rdy
);

  // The slot can take a new request if empty or emptying this cycle.
  assign free = !vld || rdy;

  // NOTE: state is updated with <= so every flop samples pre-edge values;
  // blocking = here would create order-dependent simulation races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld  <= 1'b0;
      info <= '0;
      id   <= '0;
    end else if (load) begin
      vld  <= 1'b1;
      info <= load_info;
      id   <= load_id;
    end else if (rdy) begin
      vld  <= 1'b0;
    end
  end

endmodule

// File: rtl/c_lkp_rob.sv
// Lookup reorder buffer: issues lookups to A, absorbs out-of-order responses and
// releases packets to D in B arrival order. Optional head timeout: C_LKP_TMO_EN.
module c_lkp_rob
  import c_module_pkg::*;
#(
  parameter int REQ_ID_W    = 4,
  parameter int LKP_INFO_W  = 32,
  parameter int LKP_RSLT_W  = 16,
  parameter int ODR_ID_W    = 8,
  parameter int PAYLOAD_W   = 128,
  parameter int LKP_TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  b2c_pkt_vld,
  input  logic                  b2c_pkt_lkp_en,
  input  logic [LKP_INFO_W-1:0] b2c_pkt_lkp_info,
  input  logic [ODR_ID_W-1:0]   b2c_pkt_odr_id,
  input  logic                  b2c_pkt_so,
  input  logic [PAYLOAD_W-1:0]  b2c_pkt_payload,
  output logic                  c2b_pkt_rdy,
  output logic                  c2a_lkp_vld,
  output logic [LKP_INFO_W-1:0] c2a_lkp_info,
  output logic [REQ_ID_W-1:0]   c2a_lkp_req_id,
  input  logic                  a2c_lkp_rdy,
  input  logic                  a2c_lkp_rsp_vld,
  input  logic [REQ_ID_W-1:0]   a2c_lkp_rsp_id,
  input  logic [LKP_RSLT_W-1:0] a2c_lkp_rslt,
  output logic                  c2d_pkt_vld,
  output logic [LKP_RSLT_W-1:0] c2d_pkt_lkp_rslt,
  output logic [ODR_ID_W-1:0]   c2d_pkt_odr_id,
  output logic                  c2d_pkt_so,
  output logic [PAYLOAD_W-1:0]  c2d_pkt_payload,
  input  logic                  d2c_pkt_rdy,
  output logic                  c_rob_err
`ifdef C_LKP_TMO_EN
  ,
  output logic                  c2d_pkt_tmo
`endif
);

  localparam int DEPTH = 2 ** REQ_ID_W;

  slot_state_e           state    [DEPTH];
  logic [LKP_RSLT_W-1:0] rslt_mem [DEPTH];
  logic [ODR_ID_W-1:0]   odr_mem  [DEPTH];
  logic                  so_mem   [DEPTH];
  logic [PAYLOAD_W-1:0]  pld_mem  [DEPTH];

  logic [REQ_ID_W-1:0] head, tail;
  logic [REQ_ID_W:0]   count;
  logic                issue_free, acc, rel, rsp_hit, tmo_fire;

  // count can never exceed DEPTH, so its MSB alone means "full".
  assign c2b_pkt_rdy = !rst && !count[REQ_ID_W] && issue_free;
  assign acc         = b2c_pkt_vld && c2b_pkt_rdy;
  assign c2d_pkt_vld = (count != '0) && (state[head] == SLOT_READY);
  assign rel         = c2d_pkt_vld && d2c_pkt_rdy;
  assign rsp_hit     = a2c_lkp_rsp_vld && (state[a2c_lkp_rsp_id] == SLOT_WAIT);

  // Gating with vld keeps data outputs at zero out of reset without clearing the arrays.
  assign c2d_pkt_lkp_rslt = c2d_pkt_vld ? rslt_mem[head] : '0;
  assign c2d_pkt_odr_id   = c2d_pkt_vld ? odr_mem[head]  : '0;
  assign c2d_pkt_so       = c2d_pkt_vld ? so_mem[head]   : 1'b0;
  assign c2d_pkt_payload  = c2d_pkt_vld ? pld_mem[head]  : '0;

  c_lkp_issue_reg #(
    .INFO_W (LKP_INFO_W),
    .ID_W   (REQ_ID_W)
  ) u_issue (
    .clk       (clk),
    .rst       (rst),
    .load      (acc && b2c_pkt_lkp_en),
    .load_info (b2c_pkt_lkp_info),
    .load_id   (tail),
    .free      (issue_free),
    .vld       (c2a_lkp_vld),
    .info      (c2a_lkp_info),
    .id        (c2a_lkp_req_id),
    .rdy       (a2c_lkp_rdy)
  );

`ifdef C_LKP_TMO_EN
  localparam int                TMO_W    = $clog2(LKP_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(LKP_TIMEOUT - 1);

  logic [TMO_W-1:0] tmo_cnt;
  logic             head_tmo, head_wait;

  assign head_wait   = (count != '0) && (state[head] == SLOT_WAIT);
  // A real response landing on the deadline cycle wins over the timeout.
  assign tmo_fire    = head_wait && (tmo_cnt == TMO_LAST) &&
                       !(rsp_hit && (a2c_lkp_rsp_id == head));
  assign c2d_pkt_tmo = c2d_pkt_vld && head_tmo;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt  <= '0;
      head_tmo <= 1'b0;
    end else begin
      tmo_cnt <= head_wait ? tmo_cnt + TMO_W'(1) : '0;
      if (tmo_fire)   head_tmo <= 1'b1;
      else if (rel)   head_tmo <= 1'b0;
    end
  end
`else
  assign tmo_fire = 1'b0;
`endif

  // Slot states, pointers and count. Accept, release, response and timeout
  // always target distinct slots, so their writes never collide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      c_rob_err <= 1'b0;
      for (int i = 0; i < DEPTH; i++) state[i] <= SLOT_FREE;
    end else begin
      if (rel) begin
        state[head] <= SLOT_FREE;
        head        <= head + REQ_ID_W'(1);
      end
      if (acc) begin
        state[tail] <= b2c_pkt_lkp_en ? SLOT_WAIT : SLOT_READY;
        tail        <= tail + REQ_ID_W'(1);
      end
      if (rsp_hit)              state[a2c_lkp_rsp_id] <= SLOT_READY;
      else if (a2c_lkp_rsp_vld) c_rob_err             <= 1'b1;
      if (tmo_fire)             state[head]           <= SLOT_READY;
      case ({acc, rel})
        2'b10:   count <= count + (REQ_ID_W+1)'(1);
        2'b01:   count <= count - (REQ_ID_W+1)'(1);
        default: ;
      endcase
    end
  end

  // NOTE: the payload arrays are plain storage with no reset; slot state is
  // the only thing that decides whether their contents are meaningful.
  always_ff @(posedge clk) begin
    if (acc) begin
      odr_mem[tail]  <= b2c_pkt_odr_id;
      so_mem[tail]   <= b2c_pkt_so;
      pld_mem[tail]  <= b2c_pkt_payload;
      rslt_mem[tail] <= LKP_RSLT_W'(C_RSLT_NONE);
    end
    if (rsp_hit)  rslt_mem[a2c_lkp_rsp_id] <= a2c_lkp_rslt;
    if (tmo_fire) rslt_mem[head]           <= {LKP_RSLT_W{C_RSLT_TMO_FILL}};
  end

endmodule

// File: tb/tb_c_lkp_rob.sv
// Directed self-checking bench for c_lkp_rob (DEPTH=16, LKP_TIMEOUT=8).
// The timeout scenario is compiled only when C_LKP_TMO_EN is defined.
module tb_c_lkp_rob;

  localparam int RW  = 4;
  localparam int IW  = 32;
  localparam int RSW = 16;
  localparam int OW  = 8;
  localparam int PW  = 128;

  logic           clk = 1'b0;
  logic           rst;
  logic           b2c_pkt_vld, b2c_pkt_lkp_en, b2c_pkt_so;
  logic [IW-1:0]  b2c_pkt_lkp_info;
  logic [OW-1:0]  b2c_pkt_odr_id;
  logic [PW-1:0]  b2c_pkt_payload;
  logic           c2b_pkt_rdy;
  logic           c2a_lkp_vld;
  logic [IW-1:0]  c2a_lkp_info;
  logic [RW-1:0]  c2a_lkp_req_id;
  logic           a2c_lkp_rdy, a2c_lkp_rsp_vld;
  logic [RW-1:0]  a2c_lkp_rsp_id;
  logic [RSW-1:0] a2c_lkp_rslt;
  logic           c2d_pkt_vld, c2d_pkt_so, d2c_pkt_rdy, c_rob_err;
  logic [RSW-1:0] c2d_pkt_lkp_rslt;
  logic [OW-1:0]  c2d_pkt_odr_id;
  logic [PW-1:0]  c2d_pkt_payload;
`ifdef C_LKP_TMO_EN
  logic           c2d_pkt_tmo;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  c_lkp_rob #(
    .REQ_ID_W    (RW),
    .LKP_INFO_W  (IW),
    .LKP_RSLT_W  (RSW),
    .ODR_ID_W    (OW),
    .PAYLOAD_W   (PW),
    .LKP_TIMEOUT (8)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .b2c_pkt_vld      (b2c_pkt_vld),
    .b2c_pkt_lkp_en   (b2c_pkt_lkp_en),
    .b2c_pkt_lkp_info (b2c_pkt_lkp_info),
    .b2c_pkt_odr_id   (b2c_pkt_odr_id),
    .b2c_pkt_so       (b2c_pkt_so),
    .b2c_pkt_payload  (b2c_pkt_payload),
    .c2b_pkt_rdy      (c2b_pkt_rdy),
    .c2a_lkp_vld      (c2a_lkp_vld),
    .c2a_lkp_info     (c2a_lkp_info),
    .c2a_lkp_req_id   (c2a_lkp_req_id),
    .a2c_lkp_rdy      (a2c_lkp_rdy),
    .a2c_lkp_rsp_vld  (a2c_lkp_rsp_vld),
    .a2c_lkp_rsp_id   (a2c_lkp_rsp_id),
    .a2c_lkp_rslt     (a2c_lkp_rslt),
    .c2d_pkt_vld      (c2d_pkt_vld),
    .c2d_pkt_lkp_rslt (c2d_pkt_lkp_rslt),
    .c2d_pkt_odr_id   (c2d_pkt_odr_id),
    .c2d_pkt_so       (c2d_pkt_so),
    .c2d_pkt_payload  (c2d_pkt_payload),
    .d2c_pkt_rdy      (d2c_pkt_rdy),
    .c_rob_err        (c_rob_err)
`ifdef C_LKP_TMO_EN
    ,
    .c2d_pkt_tmo      (c2d_pkt_tmo)
`endif
  );

  // Advance past one rising edge; outputs are sampled 2 ns after it.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    b2c_pkt_vld      = 1'b0;
    b2c_pkt_lkp_en   = 1'b0;
    b2c_pkt_lkp_info = '0;
    b2c_pkt_odr_id   = '0;
    b2c_pkt_so       = 1'b0;
    b2c_pkt_payload  = '0;
    a2c_lkp_rsp_vld  = 1'b0;
    a2c_lkp_rsp_id   = '0;
    a2c_lkp_rslt     = '0;
  endtask

  task automatic reset_dut();
    idle_inputs();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
  endtask

  task automatic send(input logic lkp, input logic [IW-1:0] info,
                      input logic [OW-1:0] odr, input logic [PW-1:0] pld);
    b2c_pkt_vld      = 1'b1;
    b2c_pkt_lkp_en   = lkp;
    b2c_pkt_lkp_info = info;
    b2c_pkt_odr_id   = odr;
    b2c_pkt_so       = odr[0];
    b2c_pkt_payload  = pld;
  endtask

  task automatic test_reset();
    idle_inputs();
    a2c_lkp_rdy = 1'b1;
    d2c_pkt_rdy = 1'b1;
    rst = 1'b1;
    cyc();
    cyc();
    checks++;
    if (c2b_pkt_rdy !== 1'b0 || c2a_lkp_vld !== 1'b0 || c2d_pkt_vld !== 1'b0 || c_rob_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl got rdy=%b avld=%b dvld=%b err=%b exp 0 0 0 0",
               c2b_pkt_rdy, c2a_lkp_vld, c2d_pkt_vld, c_rob_err);
    end
    checks++;
    if (c2d_pkt_payload !== '0 || c2d_pkt_odr_id !== '0 || c2a_lkp_info !== '0 || c2a_lkp_req_id !== '0) begin
      errors++;
      $display("FAIL reset_data got pld=%0h odr=%0h info=%0h id=%0h exp 0", c2d_pkt_payload,
               c2d_pkt_odr_id, c2a_lkp_info, c2a_lkp_req_id);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (c2b_pkt_rdy !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_rdy got %b exp 1", c2b_pkt_rdy);
    end
  endtask

  task automatic test_no_lookup();
    reset_dut();
    for (int i = 0; i < 4; i++) begin
      send(1'b0, '0, OW'(i + 1), PW'(32'hA0 + i));
      cyc();
      checks++;
      if (c2d_pkt_vld !== 1'b1 || c2d_pkt_odr_id !== OW'(i + 1) || c2d_pkt_payload !== PW'(32'hA0 + i) ||
          c2d_pkt_lkp_rslt !== 16'h0 || c2d_pkt_so !== 1'(i + 1)) begin
        errors++;
        $display("FAIL nolkp_pkt%0d got vld=%b odr=%0h pld=%0h rslt=%0h so=%b exp 1 %0h %0h 0 %b", i,
                 c2d_pkt_vld, c2d_pkt_odr_id, c2d_pkt_payload, c2d_pkt_lkp_rslt, c2d_pkt_so,
                 i + 1, 32'hA0 + i, 1'(i + 1));
      end
    end
    idle_inputs();
    cyc();
    checks++;
    if (c2d_pkt_vld !== 1'b0) begin
      errors++;
      $display("FAIL nolkp_drain got vld=%b exp 0", c2d_pkt_vld);
    end
  endtask

  task automatic test_out_of_order();
    logic [RW-1:0]  rsp_ids  [3] = '{4'd2, 4'd0, 4'd1};
    logic [RSW-1:0] rsp_vals [3] = '{16'h22, 16'h00, 16'h11};
    reset_dut();
    for (int i = 0; i < 3; i++) begin
      send(1'b1, IW'(32'h100 + i), OW'(i), PW'(i));
      cyc();
      checks++;
      if (c2a_lkp_vld !== 1'b1 || c2a_lkp_req_id !== RW'(i) || c2a_lkp_info !== IW'(32'h100 + i)) begin
        errors++;
        $display("FAIL ooo_issue%0d got vld=%b id=%0d info=%0h exp 1 %0d %0h", i, c2a_lkp_vld,
                 c2a_lkp_req_id, c2a_lkp_info, i, 32'h100 + i);
      end
    end
    idle_inputs();
    cyc();
    checks++;
    if (c2a_lkp_vld !== 1'b0 || c2d_pkt_vld !== 1'b0) begin
      errors++;
      $display("FAIL ooo_wait got avld=%b dvld=%b exp 0 0", c2a_lkp_vld, c2d_pkt_vld);
    end
    for (int r = 0; r < 3; r++) begin
      a2c_lkp_rsp_vld = 1'b1;
      a2c_lkp_rsp_id  = rsp_ids[r];
      a2c_lkp_rslt    = rsp_vals[r];
      cyc();
      if (r == 0) begin
        checks++;
        if (c2d_pkt_vld !== 1'b0) begin
          errors++;
          $display("FAIL ooo_early_release got vld=%b exp 0", c2d_pkt_vld);
        end
      end else begin
        checks++;
        if (c2d_pkt_vld !== 1'b1 || c2d_pkt_odr_id !== OW'(r - 1) ||
            c2d_pkt_lkp_rslt !== (r == 1 ? 16'h00 : 16'h11)) begin
          errors++;
          $display("FAIL ooo_rel%0d got vld=%b odr=%0d rslt=%0h exp 1 %0d %0h", r - 1, c2d_pkt_vld,
                   c2d_pkt_odr_id, c2d_pkt_lkp_rslt, r - 1, (r == 1 ? 16'h00 : 16'h11));
        end
      end
    end
    idle_inputs();
    cyc();
    checks++;
    if (c2d_pkt_vld !== 1'b1 || c2d_pkt_odr_id !== 8'd2 || c2d_pkt_lkp_rslt !== 16'h22) begin
      errors++;
      $display("FAIL ooo_rel2 got vld=%b odr=%0d rslt=%0h exp 1 2 22", c2d_pkt_vld, c2d_pkt_odr_id,
               c2d_pkt_lkp_rslt);
    end
    cyc();
    checks++;
    if (c2d_pkt_vld !== 1'b0 || c_rob_err !== 1'b0) begin
      errors++;
      $display("FAIL ooo_end got vld=%b err=%b exp 0 0", c2d_pkt_vld, c_rob_err);
    end
  endtask

  task automatic test_fill_wrap();
    reset_dut();
    d2c_pkt_rdy = 1'b0;
    for (int i = 0; i < 16; i++) begin
      send(1'b0, '0, OW'(i), PW'(i));
      #1;
      checks++;
      if (c2b_pkt_rdy !== 1'b1) begin
        errors++;
        $display("FAIL fill_rdy%0d got %b exp 1", i, c2b_pkt_rdy);
      end
      cyc();
    end
    send(1'b0, '0, 8'h10, PW'(16));
    #1;
    checks++;
    if (c2b_pkt_rdy !== 1'b0 || c2d_pkt_vld !== 1'b1 || c2d_pkt_odr_id !== 8'd0) begin
      errors++;
      $display("FAIL fill_full got rdy=%b vld=%b odr=%0d exp 0 1 0", c2b_pkt_rdy, c2d_pkt_vld, c2d_pkt_odr_id);
    end
    d2c_pkt_rdy = 1'b1;
    cyc();
    checks++;
    if (c2b_pkt_rdy !== 1'b1 || c2d_pkt_odr_id !== 8'd1) begin
      errors++;
      $display("FAIL fill_restore got rdy=%b odr=%0d exp 1 1", c2b_pkt_rdy, c2d_pkt_odr_id);
    end
    cyc();
    idle_inputs();
    for (int k = 2; k < 16; k++) begin
      checks++;
      if (c2d_pkt_vld !== 1'b1 || c2d_pkt_odr_id !== OW'(k) || c2d_pkt_payload !== PW'(k)) begin
        errors++;
        $display("FAIL fill_order%0d got vld=%b odr=%0d pld=%0h exp 1 %0d %0h", k, c2d_pkt_vld,
                 c2d_pkt_odr_id, c2d_pkt_payload, k, k);
      end
      cyc();
    end
    checks++;
    if (c2d_pkt_vld !== 1'b1 || c2d_pkt_odr_id !== 8'h10 || c2d_pkt_payload !== PW'(16)) begin
      errors++;
      $display("FAIL fill_wrap got vld=%b odr=%0h pld=%0h exp 1 10 10", c2d_pkt_vld, c2d_pkt_odr_id,
               c2d_pkt_payload);
    end
    cyc();
    checks++;
    if (c2d_pkt_vld !== 1'b0) begin
      errors++;
      $display("FAIL fill_empty got vld=%b exp 0", c2d_pkt_vld);
    end
  endtask

  task automatic test_backpressure();
    reset_dut();
    a2c_lkp_rdy = 1'b0;
    send(1'b1, 32'hDEADBEEF, 8'h5, PW'(5));
    cyc();
    send(1'b1, 32'h12345678, 8'h6, PW'(6));
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if (c2a_lkp_vld !== 1'b1 || c2a_lkp_info !== 32'hDEADBEEF || c2a_lkp_req_id !== 4'd0 ||
          c2b_pkt_rdy !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d got avld=%b info=%0h id=%0d rdy=%b exp 1 deadbeef 0 0", c, c2a_lkp_vld,
                 c2a_lkp_info, c2a_lkp_req_id, c2b_pkt_rdy);
      end
      cyc();
    end
    a2c_lkp_rdy = 1'b1;
    #1;
    checks++;
    if (c2b_pkt_rdy !== 1'b1) begin
      errors++;
      $display("FAIL bp_rdy_comb got %b exp 1", c2b_pkt_rdy);
    end
    cyc();
    idle_inputs();
    checks++;
    if (c2a_lkp_vld !== 1'b1 || c2a_lkp_info !== 32'h12345678 || c2a_lkp_req_id !== 4'd1) begin
      errors++;
      $display("FAIL bp_reload got avld=%b info=%0h id=%0d exp 1 12345678 1", c2a_lkp_vld, c2a_lkp_info,
               c2a_lkp_req_id);
    end
    cyc();
    checks++;
    if (c2a_lkp_vld !== 1'b0) begin
      errors++;
      $display("FAIL bp_clear got %b exp 0", c2a_lkp_vld);
    end
  endtask

  task automatic test_err_reset();
    reset_dut();
    a2c_lkp_rsp_vld = 1'b1;
    a2c_lkp_rsp_id  = 4'd7;
    a2c_lkp_rslt    = 16'hBEEF;
    cyc();
    idle_inputs();
    checks++;
    if (c_rob_err !== 1'b1 || c2d_pkt_vld !== 1'b0) begin
      errors++;
      $display("FAIL err_free_rsp got err=%b vld=%b exp 1 0", c_rob_err, c2d_pkt_vld);
    end
    cyc();
    cyc();
    checks++;
    if (c_rob_err !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky got %b exp 1", c_rob_err);
    end
    d2c_pkt_rdy = 1'b0;
    send(1'b0, '0, 8'h31, PW'(32'h31));
    cyc();
    send(1'b0, '0, 8'h32, PW'(32'h32));
    cyc();
    idle_inputs();
    checks++;
    if (c2d_pkt_vld !== 1'b1 || c2d_pkt_odr_id !== 8'h31) begin
      errors++;
      $display("FAIL err_pre_reset got vld=%b odr=%0h exp 1 31", c2d_pkt_vld, c2d_pkt_odr_id);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (c2d_pkt_vld !== 1'b0 || c2b_pkt_rdy !== 1'b0 || c_rob_err !== 1'b0 || c2d_pkt_payload !== '0) begin
      errors++;
      $display("FAIL err_async_reset got vld=%b rdy=%b err=%b pld=%0h exp 0 0 0 0", c2d_pkt_vld,
               c2b_pkt_rdy, c_rob_err, c2d_pkt_payload);
    end
    cyc();
    rst = 1'b0;
    d2c_pkt_rdy = 1'b1;
    #1;
    checks++;
    if (c2d_pkt_vld !== 1'b0 || c_rob_err !== 1'b0 || c2b_pkt_rdy !== 1'b1) begin
      errors++;
      $display("FAIL err_post_reset got vld=%b err=%b rdy=%b exp 0 0 1", c2d_pkt_vld, c_rob_err, c2b_pkt_rdy);
    end
    a2c_lkp_rsp_vld = 1'b1;
    a2c_lkp_rsp_id  = 4'd0;
    cyc();
    idle_inputs();
    checks++;
    if (c_rob_err !== 1'b1 || c2d_pkt_vld !== 1'b0) begin
      errors++;
      $display("FAIL err_stale_rsp got err=%b vld=%b exp 1 0", c_rob_err, c2d_pkt_vld);
    end
  endtask

`ifdef C_LKP_TMO_EN
  task automatic test_timeout();
    int waited;
    reset_dut();
    send(1'b1, 32'hCAFE, 8'h44, PW'(32'h44));
    cyc();
    idle_inputs();
    waited = 0;
    while (c2d_pkt_vld !== 1'b1 && waited < 20) begin
      waited++;
      cyc();
    end
    checks++;
    if (waited != 8) begin
      errors++;
      $display("FAIL tmo_wait_cycles got %0d exp 8", waited);
    end
    checks++;
    if (c2d_pkt_vld !== 1'b1 || c2d_pkt_lkp_rslt !== 16'hFFFF || c2d_pkt_tmo !== 1'b1 ||
        c2d_pkt_odr_id !== 8'h44) begin
      errors++;
      $display("FAIL tmo_release got vld=%b rslt=%0h tmo=%b odr=%0h exp 1 ffff 1 44", c2d_pkt_vld,
               c2d_pkt_lkp_rslt, c2d_pkt_tmo, c2d_pkt_odr_id);
    end
    cyc();
    a2c_lkp_rsp_vld = 1'b1;
    a2c_lkp_rsp_id  = 4'd0;
    a2c_lkp_rslt    = 16'h1234;
    cyc();
    idle_inputs();
    checks++;
    if (c_rob_err !== 1'b1 || c2d_pkt_vld !== 1'b0 || c2d_pkt_tmo !== 1'b0) begin
      errors++;
      $display("FAIL tmo_late_rsp got err=%b vld=%b tmo=%b exp 1 0 0", c_rob_err, c2d_pkt_vld, c2d_pkt_tmo);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog expired before the sequence completed");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_no_lookup();
    test_out_of_order();
    test_fill_wrap();
    test_backpressure();
    test_err_reset();
`ifdef C_LKP_TMO_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
